debug_dump_collector: RTL
=========================

// Module: debug_dump_collector
// PURPOSE
//  Host-side end of the MIPS debug link, on the other side of the UART from the on-chip debug unit.
//  On request, sends the step command byte, then receives the dump stream:
//   PC, NUMBER_REGISTERS registers, ALU result; each is a 32-bit word sent MSB byte first.
//  Reassembles the bytes into words and presents each word with its index.
//  A receive timeout recovers the block from a truncated dump.
// PARAMETERS
//  NB               32        word width (exactly 4 bytes)
//  DATA_BITS        8         UART byte width
//  NUMBER_REGISTERS 32        register words per dump; words per frame N_WORDS = NUMBER_REGISTERS+2
//  NB_IDX           6         $clog2(N_WORDS), width of the word index
//  CMD_STEP         8'h73     command byte that triggers one step plus dump
//  TIMEOUT_CYCLES   1000000   maximum idle cycles allowed between bytes while receiving
//  NB_STATE         3         state debug width
// PORTS
//  i_clk            in   1          clock
//  i_reset          in   1          synchronous, active-high reset
//  i_start          in   1          1-cycle pulse: request one step and dump
//  i_uart_rx_ready  in   1          1-cycle pulse: i_uart_rx_data is valid
//  i_uart_rx_data   in   DATA_BITS  received byte
//  i_uart_tx_done   in   1          1-cycle pulse: UART TX finished the byte
//  o_uart_tx_data   out  DATA_BITS  byte to transmit
//  o_uart_tx_ready  out  1          TX request level
//  o_word_valid     out  1          1-cycle pulse: o_word and o_word_index are valid
//  o_word           out  NB         reassembled word
//  o_word_index     out  NB_IDX     0=PC, 1..NUMBER_REGISTERS = reg 0..31, N_WORDS-1 = ALU result
//  o_frame_done     out  1          1-cycle pulse on the last word of the frame
//  o_timeout        out  1          1-cycle pulse: frame aborted by timeout
//  o_busy           out  1          high in any state except IDLE
//  o_state_debug    out  NB_STATE   current state encoding
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, byte/word/timeout counters 0, shift register 0.
//  States: IDLE=0, SEND_CMD=1, WAIT_TX=2, RECV=3.
//  IDLE:
//   - i_start -> SEND_CMD.
//   - i_uart_rx_ready is ignored.
//  SEND_CMD:
//   - Registers o_uart_tx_data=CMD_STEP and o_uart_tx_ready=1; next state WAIT_TX.
//   - o_uart_tx_ready rises the 2nd cycle after i_start.
//  WAIT_TX:
//   - o_uart_tx_ready held at 1 until i_uart_tx_done.
//   - On i_uart_tx_done: o_uart_tx_ready=0 the next cycle; state -> RECV.
//   - Bytes received in WAIT_TX are captured, including one arriving in the same cycle as tx_done.
//  RECV and WAIT_TX, byte capture on each i_uart_rx_ready:
//   - shift = {shift[NB-DATA_BITS-1:0], byte}.
//   - byte_cnt (2 bits) increments and wraps 3->0.
//   - On the 4th byte: the next cycle has o_word = assembled word, o_word_index = word_cnt, o_word_valid=1.
//   - Then word_cnt increments; latency is 1 cycle from the rx pulse.
//  Last word (word_cnt == N_WORDS-1):
//   - o_frame_done=1 in the same cycle as its o_word_valid.
//   - word_cnt and byte_cnt return to 0; state -> IDLE.
//  o_word holds its value between pulses; o_word_index likewise.
//  Timeout (RECV only):
//   - Counter cleared on entry to RECV and on every captured byte; increments otherwise.
//   - On reaching TIMEOUT_CYCLES: o_timeout pulses next cycle.
//   - Counters cleared, no o_frame_done; state -> IDLE.
//  i_start is ignored when not in IDLE.
//  Synchronous reset in any state aborts the frame immediately; partial bytes are discarded.
//  Counters never exceed their range: byte_cnt wraps mod 4; word_cnt is reset at N_WORDS-1.
// TESTING
//  1. Reset, then i_start pulse:
//     - o_uart_tx_data=0x73 and o_uart_tx_ready=1 two cycles later.
//     - Held 20 cycles; tx_done -> o_uart_tx_ready=0 the next cycle, o_busy=1.
//  2. Feed 136 bytes: PC 00 00 00 04; reg k = k*0x01010101; ALU DE AD BE EF.
//     - Expect 34 o_word_valid pulses, indices 0..33 with matching words.
//     - o_frame_done with index 33 and word 0xDEADBEEF; then IDLE.
//  3. Stop after 10 bytes; wait TIMEOUT_CYCLES (use a small TIMEOUT_CYCLES=50 build):
//     - o_timeout pulses once, no frame_done, state IDLE.
//     - A new full frame then decodes with index 0 = PC.
//  4. Protocol filtering:
//     - rx bytes while IDLE produce no words.
//     - i_start pulses mid-RECV do not change state or re-send the command.
//  5. Assert i_reset for one cycle after byte 50:
//     - All outputs 0, state IDLE.
//     - The next start plus frame decodes cleanly from index 0.
//  6. i_uart_rx_ready coincident with i_uart_tx_done in WAIT_TX:
//     - The byte is captured as byte 0 of the PC; the frame completes correctly.

Source files
------------

// File: rtl/debug_dump_collector.sv
// Host-side debug link endpoint: sends the step command over the UART, then
// reassembles the big-endian dump stream (PC, registers, ALU result) into indexed words.
module debug_dump_collector #(
    parameter int          NB               = 32,
    parameter int          DATA_BITS        = 8,
    parameter int          NUMBER_REGISTERS = 32,
    parameter int          NB_IDX           = 6,
    parameter logic [7:0]  CMD_STEP         = 8'h73,
    parameter int          TIMEOUT_CYCLES   = 1000000,
    parameter int          NB_STATE         = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_uart_rx_ready,
    input  logic [DATA_BITS-1:0] i_uart_rx_data,
    input  logic                 i_uart_tx_done,
    output logic [DATA_BITS-1:0] o_uart_tx_data,
    output logic                 o_uart_tx_ready,
    output logic                 o_word_valid,
    output logic [NB-1:0]        o_word,
    output logic [NB_IDX-1:0]    o_word_index,
    output logic                 o_frame_done,
    output logic                 o_timeout,
    output logic                 o_busy,
    output logic [NB_STATE-1:0]  o_state_debug
);

    localparam int N_WORDS = NUMBER_REGISTERS + 2;
    localparam int NB_TMO  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int NB_SH   = NB - DATA_BITS;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE     = NB_STATE'(0),
        ST_SEND_CMD = NB_STATE'(1),
        ST_WAIT_TX  = NB_STATE'(2),
        ST_RECV     = NB_STATE'(3)
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   word_valid_q, word_valid_d;
    logic [NB-1:0]          word_q, word_d;
    logic [NB_IDX-1:0]      word_index_q, word_index_d;
    logic                   frame_done_q, frame_done_d;
    logic                   timeout_q, timeout_d;
    logic [NB_SH-1:0]       shift_q, shift_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [NB_IDX-1:0]      word_cnt_q, word_cnt_d;
    logic [NB_TMO-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                   capture;

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        tx_ready_d   = tx_ready_q;
        word_valid_d = 1'b0;
        word_d       = word_q;
        word_index_d = word_index_q;
        frame_done_d = 1'b0;
        timeout_d    = 1'b0;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        capture      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) state_d = ST_SEND_CMD;
            end
            ST_SEND_CMD: begin
                tx_data_d  = CMD_STEP;
                tx_ready_d = 1'b1;
                state_d    = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                capture = i_uart_rx_ready;
                if (i_uart_tx_done) begin
                    tx_ready_d = 1'b0;
                    tmo_cnt_d  = '0;
                    state_d    = ST_RECV;
                end
            end
            ST_RECV: begin
                capture = i_uart_rx_ready;
                if (!i_uart_rx_ready) begin
                    if (tmo_cnt_q == NB_TMO'(TIMEOUT_CYCLES - 1)) begin
                        timeout_d  = 1'b1;
                        tmo_cnt_d  = '0;
                        byte_cnt_d = '0;
                        word_cnt_d = '0;
                        shift_d    = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Byte capture overrides the state-specific defaults above for the counters.
        if (capture) begin
            shift_d    = {shift_q[NB_SH-DATA_BITS-1:0], i_uart_rx_data};
            byte_cnt_d = byte_cnt_q + 1'b1;
            tmo_cnt_d  = '0;
            if (byte_cnt_q == 2'd3) begin
                word_d       = {shift_q, i_uart_rx_data};
                word_index_d = word_cnt_q;
                word_valid_d = 1'b1;
                if (word_cnt_q == NB_IDX'(N_WORDS - 1)) begin
                    frame_done_d = 1'b1;
                    word_cnt_d   = '0;
                    byte_cnt_d   = '0;
                    tx_ready_d   = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            tx_data_q    <= '0;
            tx_ready_q   <= 1'b0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
            word_index_q <= '0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_ready_q   <= tx_ready_d;
            word_valid_q <= word_valid_d;
            word_q       <= word_d;
            word_index_q <= word_index_d;
            frame_done_q <= frame_done_d;
            timeout_q    <= timeout_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign o_uart_tx_data  = tx_data_q;
    assign o_uart_tx_ready = tx_ready_q;
    assign o_word_valid    = word_valid_q;
    assign o_word          = word_q;
    assign o_word_index    = word_index_q;
    assign o_frame_done    = frame_done_q;
    assign o_timeout       = timeout_q;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_state_debug   = state_q;

endmodule
